// File: rtl/da_serial_acc.sv
// -----------------------------------------------------------------------------
// da_serial_acc
//
// Bit-serial distributed-arithmetic controller/accumulator for the fixed 3-tap
// inner product  y = 2*x0 + 3*x1 + 1*x2  on unsigned W-bit samples.
//
// The block sits on both sides of an external 3-input DA coefficient LUT.
// Each accumulate cycle presents one bit from each sample as the LUT address
// (LSB first). It then adds the LUT result, weighted by the bit position, into
// the accumulator. A start edge followed by W accumulate edges gives one
// inner product, so back-to-back operation yields one result per W+1 clocks.
//
// Ports
//   clk        in   1     rising-edge clock
//   reset      in   1     synchronous reset, active-low (0 = reset)
//   start      in   1     load x0..x2 and begin; honoured only when busy=0
//   x0         in   W     sample for coefficient 2 (unsigned)
//   x1         in   W     sample for coefficient 3 (unsigned)
//   x2         in   W     sample for coefficient 1 (unsigned)
//   table_in   out  3     LUT address {x2 bit k, x1 bit k, x0 bit k}
//   table_out  in   3     LUT data, combinational from table_in (0..6)
//   busy       out  1     high while accumulating
//   y          out  W+3   result register, holds until next completion/reset
//   y_valid    out  1     one-cycle pulse when y has just been updated
// -----------------------------------------------------------------------------
module da_serial_acc #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [W-1:0]   x0,
    input  logic [W-1:0]   x1,
    input  logic [W-1:0]   x2,
    output logic [2:0]     table_in,
    input  logic [2:0]     table_out,
    output logic           busy,
    output logic [W+2:0]   y,
    output logic           y_valid
);

    // Bit-position counter width; a 1-bit counter is kept even for W=1.
    localparam int KW = (W > 1) ? $clog2(W) : 1;
    // 6*(2^W-1) < 2^(W+3), so W+3 bits can never wrap.
    localparam int AW = W + 3;
    localparam logic [KW-1:0] K_LAST = KW'(W - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACC  = 1'b1
    } state_t;

    state_t          state_reg, state_next;
    logic [KW-1:0]   k_reg, k_next;
    logic [AW-1:0]   acc_reg, acc_next;
    logic [AW-1:0]   y_reg, y_next;
    logic            y_valid_reg, y_valid_next;

    // Control strobes for the shift registers, decoded by the FSM.
    logic            load;
    logic            shift;

    // One shift register per tap, index gi matches sample xgi.
    logic [W-1:0]    x_bus   [3];
    logic [W-1:0]    sr_reg  [3];
    logic [W-1:0]    sr_next [3];
    logic [2:0]      lsb_bits;

    // LUT result weighted by the current bit position.
    logic [AW-1:0]   term;

    assign x_bus[0] = x0;
    assign x_bus[1] = x1;
    assign x_bus[2] = x2;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_tap
            // Load on an accepted start, shift right while accumulating,
            // otherwise hold. The LSB always carries the current bit k.
            assign sr_next[gi] = load  ? x_bus[gi] :
                                 shift ? (sr_reg[gi] >> 1) :
                                         sr_reg[gi];
            assign lsb_bits[gi] = sr_reg[gi][0];
        end
    endgenerate

    assign term = AW'(table_out) << k_reg;

    // -------------------------------------------------------------------------
    // Next-state and datapath control
    // -------------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        k_next       = k_reg;
        acc_next     = acc_reg;
        y_next       = y_reg;
        y_valid_next = 1'b0;
        load         = 1'b0;
        shift        = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    acc_next   = '0;
                    k_next     = '0;
                    state_next = S_ACC;
                end
            end

            S_ACC: begin
                shift    = 1'b1;
                acc_next = acc_reg + term;
                k_next   = k_reg + 1'b1;
                if (k_reg == K_LAST) begin
                    // The final addend goes straight into y so the result
                    // appears on the same edge as the last accumulation.
                    y_next       = acc_reg + term;
                    y_valid_next = 1'b1;
                    k_next       = '0;
                    state_next   = S_IDLE;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= S_IDLE;
            k_reg       <= '0;
            acc_reg     <= '0;
            y_reg       <= '0;
            y_valid_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            k_reg       <= k_next;
            acc_reg     <= acc_next;
            y_reg       <= y_next;
            y_valid_reg <= y_valid_next;
        end
    end

    generate
        for (gi = 0; gi < 3; gi++) begin : g_sr
            always_ff @(posedge clk) begin
                if (!reset) begin
                    sr_reg[gi] <= '0;
                end else begin
                    sr_reg[gi] <= sr_next[gi];
                end
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign busy     = (state_reg == S_ACC);
    // Address is forced to zero outside ACC so the LUT sees a quiet bus.
    assign table_in = busy ? lsb_bits : 3'b000;
    assign y        = y_reg;
    assign y_valid  = y_valid_reg;

endmodule
